// File: rtl/spu_pkg.sv
// ----------------------------------------------------------------------------
// spu_pkg
// Shared constants and types for the register-fetch stage and its register
// file.
//   ex_bundle_t : operand/control bundle registered toward the execute stage
//   wb_port_t   : one register-file write port (enable, address, data)
// ----------------------------------------------------------------------------
package spu_pkg;

   localparam int NUM_REGS = 128;
   localparam int DATA_W   = 128;
   localparam int ADDR_W   = 7;
   localparam int OP_W     = 11;
   localparam int IMM_W    = 18;

   localparam logic [OP_W-1:0] NOP_OP = 11'b0;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [2:0]        format;
      logic [ADDR_W-1:0] rt_addr;
      logic [IMM_W-1:0]  imm;
      logic              reg_write;
      logic [DATA_W-1:0] ra;
      logic [DATA_W-1:0] rb;
      logic [DATA_W-1:0] rc;
   } ex_bundle_t;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_port_t;

endpackage

// File: rtl/spu_regfile.sv
// ----------------------------------------------------------------------------
// spu_regfile
// 128 x 128-bit register file, two write ports and three combinational read
// ports. Cleared to zero by synchronous reset.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   port_a, port_b        write ports; port_a wins on an address collision
//   ra/rb/rc_addr         read addresses
//   ra/rb/rc_data         read data (array contents, no bypass)
// ----------------------------------------------------------------------------
module spu_regfile
   import spu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  wb_port_t          port_a,
   input  wb_port_t          port_b,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   input  logic [ADDR_W-1:0] rc_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic [DATA_W-1:0] rc_data
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];

   // Port B is written first so that port A (the younger result) overrides it
   // when both target the same register in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (port_b.en) mem_q[port_b.addr] <= port_b.data;
         if (port_a.en) mem_q[port_a.addr] <= port_a.data;
      end
   end

   assign ra_data = mem_q[ra_addr];
   assign rb_data = mem_q[rb_addr];
   assign rc_data = mem_q[rc_addr];

endmodule

// File: rtl/rf_fetch_stage.sv
// ----------------------------------------------------------------------------
// rf_fetch_stage
// Register-fetch stage ahead of the single-precision execute unit. Reads three
// source operands, optionally bypasses same-cycle writebacks, and registers
// the operand/control bundle toward execute with stall (hold) and flush
// (bubble) control. One cycle of latency.
// Build option:
//   RF_WRITE_BYPASS_EN  forward same-cycle port A / port B writes to operands
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   in_valid, op, format, rt_addr, ra/rb/rc_addr, imm, reg_write
//                                 decoded instruction
//   stall, flush                  hold outputs / insert bubble (stall wins)
//   wb_en/addr/data               write port A (stage-6 result)
//   int_en/addr/data              write port B (stage-7 result)
//   *_ex                          registered bundle to execute
// ----------------------------------------------------------------------------
module rf_fetch_stage
   import spu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [OP_W-1:0]   op,
   input  logic [2:0]        format,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   input  logic [ADDR_W-1:0] rc_addr,
   input  logic [IMM_W-1:0]  imm,
   input  logic              reg_write,
   input  logic              stall,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              int_en,
   input  logic [ADDR_W-1:0] int_addr,
   input  logic [DATA_W-1:0] int_data,
   output logic [OP_W-1:0]   op_ex,
   output logic [2:0]        format_ex,
   output logic [ADDR_W-1:0] rt_addr_ex,
   output logic [IMM_W-1:0]  imm_ex,
   output logic              reg_write_ex,
   output logic [DATA_W-1:0] ra_ex,
   output logic [DATA_W-1:0] rb_ex,
   output logic [DATA_W-1:0] rc_ex
);

   wb_port_t          port_a, port_b;
   logic [DATA_W-1:0] ra_arr, rb_arr, rc_arr;
   logic [DATA_W-1:0] ra_fwd, rb_fwd, rc_fwd;
   ex_bundle_t        ex_d, ex_q;

   assign port_a = '{en: wb_en,  addr: wb_addr,  data: wb_data};
   assign port_b = '{en: int_en, addr: int_addr, data: int_data};

   spu_regfile u_regfile (
      .clk     (clk),
      .reset   (reset),
      .port_a  (port_a),
      .port_b  (port_b),
      .ra_addr (ra_addr),
      .rb_addr (rb_addr),
      .rc_addr (rc_addr),
      .ra_data (ra_arr),
      .rb_data (rb_arr),
      .rc_data (rc_arr)
   );

`ifdef RF_WRITE_BYPASS_EN
   // Port A carries the younger result, so it is checked before port B.
   function automatic logic [DATA_W-1:0] fwd_operand(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] arr_val,
      input wb_port_t          pa,
      input wb_port_t          pb
   );
      if (pa.en && pa.addr == addr)      return pa.data;
      else if (pb.en && pb.addr == addr) return pb.data;
      else                               return arr_val;
   endfunction

   assign ra_fwd = fwd_operand(ra_addr, ra_arr, port_a, port_b);
   assign rb_fwd = fwd_operand(rb_addr, rb_arr, port_a, port_b);
   assign rc_fwd = fwd_operand(rc_addr, rc_arr, port_a, port_b);
`else
   // Same-cycle writes become visible one cycle later; decode covers the gap.
   assign ra_fwd = ra_arr;
   assign rb_fwd = rb_arr;
   assign rc_fwd = rc_arr;
`endif

   always_comb begin
      ex_d = ex_q;
      if (stall) begin
         ex_d = ex_q;
      end else if (flush || !in_valid) begin
         ex_d        = '0;
         ex_d.op     = NOP_OP;
      end else begin
         ex_d.op        = op;
         ex_d.format    = format;
         ex_d.rt_addr   = rt_addr;
         ex_d.imm       = imm;
         ex_d.reg_write = reg_write;
         ex_d.ra        = ra_fwd;
         ex_d.rb        = rb_fwd;
         ex_d.rc        = rc_fwd;
      end
   end

   // ---- RF -> EX pipeline register boundary ----
   always_ff @(posedge clk) begin
      if (reset) ex_q <= '0;
      else       ex_q <= ex_d;
   end

   assign op_ex        = ex_q.op;
   assign format_ex    = ex_q.format;
   assign rt_addr_ex   = ex_q.rt_addr;
   assign imm_ex       = ex_q.imm;
   assign reg_write_ex = ex_q.reg_write;
   assign ra_ex        = ex_q.ra;
   assign rb_ex        = ex_q.rb;
   assign rc_ex        = ex_q.rc;

endmodule

// File: tb/tb_rf_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_rf_fetch_stage
// Directed bench for rf_fetch_stage. Inputs change 1 time unit after the
// rising edge; outputs are checked at the same point, after the edge has
// settled. Honours RF_WRITE_BYPASS_EN for the same-cycle write case.
// ----------------------------------------------------------------------------
module tb_rf_fetch_stage;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [10:0]  op;
   logic [2:0]   format;
   logic [6:0]   rt_addr, ra_addr, rb_addr, rc_addr;
   logic [17:0]  imm;
   logic         reg_write;
   logic         stall, flush;
   logic         wb_en, int_en;
   logic [6:0]   wb_addr, int_addr;
   logic [127:0] wb_data, int_data;
   logic [10:0]  op_ex;
   logic [2:0]   format_ex;
   logic [6:0]   rt_addr_ex;
   logic [17:0]  imm_ex;
   logic         reg_write_ex;
   logic [127:0] ra_ex, rb_ex, rc_ex;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] D1   = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;
   localparam logic [127:0] D3   = 128'h33333333_0000FFFF_A5A5A5A5_12345678;
   localparam logic [127:0] D5   = 128'h55555555_66666666_77777777_88888888;
   localparam logic [10:0]  OP_A = 11'b01011000100;
   localparam logic [10:0]  OP_B = 11'b00110011001;

   rf_fetch_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .format(format),
      .rt_addr(rt_addr), .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
      .imm(imm), .reg_write(reg_write), .stall(stall), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .int_en(int_en), .int_addr(int_addr), .int_data(int_data),
      .op_ex(op_ex), .format_ex(format_ex), .rt_addr_ex(rt_addr_ex),
      .imm_ex(imm_ex), .reg_write_ex(reg_write_ex),
      .ra_ex(ra_ex), .rb_ex(rb_ex), .rc_ex(rc_ex)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; op = '0; format = '0; rt_addr = '0;
      ra_addr = '0; rb_addr = '0; rc_addr = '0; imm = '0; reg_write = 1'b0;
      stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      int_en = 1'b0; int_addr = '0; int_data = '0;
      #1;
      tick(); tick();

      // 1. reset state, then idle read of r5
      reset = 1'b0;
      tick();
      check("reset_op",   {117'b0, op_ex}, 128'd0);
      check("reset_rw",   {127'b0, reg_write_ex}, 128'd0);
      check("reset_ra",   ra_ex, 128'd0);
      check("reset_rt",   {121'b0, rt_addr_ex}, 128'd0);
      in_valid = 1'b1; op = 11'h123; ra_addr = 7'd5;
      tick();
      check("idle_r5_ra", ra_ex, 128'd0);
      check("idle_r5_op", {117'b0, op_ex}, {117'b0, 11'h123});

      // 2. port A write to r10 with no instruction, then read it back
      in_valid = 1'b0; wb_en = 1'b1; wb_addr = 7'd10; wb_data = D1;
      tick();
      check("novalid_bubble_op", {117'b0, op_ex}, 128'd0);
      wb_en = 1'b0;
      in_valid = 1'b1; op = OP_A; ra_addr = 7'd10; rb_addr = 7'd0; rc_addr = 7'd0;
      rt_addr = 7'd20; imm = 18'h25A5A; format = 3'd3; reg_write = 1'b1;
      tick();
      check("rd_r10_ra",  ra_ex, D1);
      check("rd_r10_op",  {117'b0, op_ex}, {117'b0, OP_A});
      check("rd_r10_fmt", {125'b0, format_ex}, 128'd3);
      check("rd_r10_rt",  {121'b0, rt_addr_ex}, 128'd20);
      check("rd_r10_imm", {110'b0, imm_ex}, {110'b0, 18'h25A5A});
      check("rd_r10_rw",  {127'b0, reg_write_ex}, 128'd1);

      // 3. same-cycle write/read of r3
      wb_en = 1'b1; wb_addr = 7'd3; wb_data = D3; ra_addr = 7'd3;
      tick();
`ifdef RF_WRITE_BYPASS_EN
      check("samecyc_ra", ra_ex, D3);
`else
      check("samecyc_ra", ra_ex, 128'd0);
`endif
      wb_en = 1'b0;
      tick();
      check("reissue_ra", ra_ex, D3);

      // 4. collision on r7 (A wins), port B alone on r11
      in_valid = 1'b0;
      wb_en = 1'b1; wb_addr = 7'd7; wb_data = 128'h1;
      int_en = 1'b1; int_addr = 7'd7; int_data = 128'h2;
      tick();
      wb_en = 1'b0; int_addr = 7'd11; int_data = 128'h55;
      tick();
      int_en = 1'b0;
      in_valid = 1'b1; ra_addr = 7'd7; rb_addr = 7'd11; rc_addr = 7'd10;
      reg_write = 1'b0; rt_addr = 7'd9;
      tick();
      check("collide_ra", ra_ex, 128'h1);
      check("portb_rb",   rb_ex, 128'h55);
      check("r10_rc",     rc_ex, D1);
      check("norw_rt",    {121'b0, rt_addr_ex}, 128'd9);
      check("norw_rw",    {127'b0, reg_write_ex}, 128'd0);

      // 5. stall holds A for 3 cycles while B is presented; r10 rewritten
      op = OP_A; ra_addr = 7'd10; rb_addr = 7'd0; rc_addr = 7'd0; reg_write = 1'b1;
      tick();
      check("issueA_op", {117'b0, op_ex}, {117'b0, OP_A});
      stall = 1'b1; op = OP_B; ra_addr = 7'd7;
      wb_en = 1'b1; wb_addr = 7'd10; wb_data = D5;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_hold_op", {117'b0, op_ex}, {117'b0, OP_A});
         check("stall_hold_ra", ra_ex, D1);
      end
      stall = 1'b0; wb_en = 1'b0;
      tick();
      check("afterstall_op", {117'b0, op_ex}, {117'b0, OP_B});
      check("afterstall_ra", ra_ex, 128'h1);

      // 6. flush, flush+stall, reset during stall
      flush = 1'b1;
      tick();
      check("flush_op", {117'b0, op_ex}, 128'd0);
      check("flush_ra", ra_ex, 128'd0);
      check("flush_rw", {127'b0, reg_write_ex}, 128'd0);
      flush = 1'b0; op = OP_A; ra_addr = 7'd10;
      tick();
      check("reissueA_ra", ra_ex, D5);
      stall = 1'b1; flush = 1'b1; op = OP_B;
      tick();
      check("stallflush_op", {117'b0, op_ex}, {117'b0, OP_A});
      check("stallflush_ra", ra_ex, D5);
      reset = 1'b1; flush = 1'b0;
      tick();
      check("rst_stall_op", {117'b0, op_ex}, 128'd0);
      check("rst_stall_ra", ra_ex, 128'd0);
      reset = 1'b0; stall = 1'b0; in_valid = 1'b1; ra_addr = 7'd10;
      tick();
      check("rst_clears_rf", ra_ex, 128'd0);
      check("post_rst_op", {117'b0, op_ex}, {117'b0, OP_B});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
